instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Writer side of the instruction memory: fills it from a byte stream, e.g. a UART receiver, while the core fetches nothing.
- Holds the core in reset until the program is loaded.
- Frame: 2-byte little-endian word count N, then N little-endian 32-bit words. Each word is written to BASE_ADDRESS + 4*index.
- Sits between the serial receive path and the instruction memory write port.

Parameters:
- BASE_ADDRESS, 32'h0000_0000, byte address of the first word written.
- MAX_WORDS, 1024, largest accepted N; a larger N is a framing error.

Ports:
- i_clk  input  1  clock
- i_arst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse; starts a load from IDLE, DONE or ERROR
- i_byteValid  input  1  byte source has data
- i_byteData  input  8  byte from source
- o_byteReady  output  1  loader accepts a byte this cycle
- o_imemWriteEn  output  1  instruction memory write strobe
- o_imemWriteAddress  output  32  instruction memory byte address
- o_imemWriteData  output  32  assembled instruction word
- o_coreSrst  output  1  synchronous reset to the core, active-high
- o_busy  output  1  load in progress
- o_done  output  1  last load completed successfully
- o_error  output  1  last load aborted

Behaviour:
- Reset: one clock (i_clk); reset is asynchronous and active-low (i_arst_n). While i_arst_n = 0, all registers clear asynchronously.
  - Reset values: state IDLE, o_byteReady=0, o_imemWriteEn=0, o_imemWriteAddress=0, o_imemWriteData=0, o_coreSrst=1, o_busy=0, o_done=0, o_error=0.
- Byte handshake: a byte transfers on a rising edge where i_byteValid && o_byteReady. o_byteReady is a registered function of state only; it never depends on i_byteValid.
- States and transitions:
  - IDLE: i_start -> LEN_LO.
  - LEN_LO: accept byte -> len[7:0]; go to LEN_HI.
  - LEN_HI: accept byte -> len[15:8]; then:
    - len == 0 -> DONE (or CHECK with the feature enabled);
    - len > MAX_WORDS -> ERROR;
    - otherwise -> WORD with byteCnt=0, index=0.
  - WORD: each accepted byte goes to word[8*byteCnt +: 8]; byteCnt increments. After the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - o_imemWriteEn=1, o_imemWriteAddress=BASE_ADDRESS + {index,2'b00} (32-bit, wraps mod 2^32), o_imemWriteData=word.
    - index increments.
    - index+1 == len -> DONE (or CHECK); else -> WORD.
  - DONE: o_done=1, o_coreSrst=0. i_start -> LEN_LO, clearing o_done and reasserting o_coreSrst the next cycle.
  - ERROR: o_error=1, o_coreSrst=1. i_start -> LEN_LO, clearing o_error.
- o_byteReady=1 only in LEN_LO, LEN_HI, WORD and CHECK. No byte is accepted in the WRITE cycle, so the maximum rate is 4 bytes per 5 cycles.
- o_busy=1 in LEN_LO, LEN_HI, WORD, WRITE and CHECK. o_coreSrst=1 in every state except DONE.
- Latency: o_imemWriteEn rises the cycle after the 4th byte of a word is accepted.
- i_start is ignored while o_busy=1.
- Asynchronous reset mid-load: return to IDLE with o_coreSrst=1; partially written memory is not cleared.
- o_imemWriteAddress and o_imemWriteData hold their last values when o_imemWriteEn=0.

Optional Feature:
- Macro: INSTR_MEM_LOADER_CHECKSUM_EN.
- Defined: a trailing checksum byte follows the last word (or LEN_HI when len=0). State CHECK accepts it.
  - Checksum byte == XOR of all preceding frame bytes, including both length bytes -> DONE.
  - Otherwise -> ERROR; o_coreSrst stays 1. Words already written remain in memory.
- Undefined: CHECK state and XOR register are absent; there is no trailing byte.

Decomposition:
- pa_riscv package gains:
  - typedef enum loaderState_t {IDLE, LEN_LO, LEN_HI, WORD, WRITE, CHECK, DONE, ERROR};
  - localparam LOADER_LEN_BYTES = 2.
- One sub-module, loader_word_assembler: byte-lane shift-in with a 2-bit byteCnt; outputs the word and a wordComplete flag.
- FSM, index counter and address generation stay in instr_mem_loader.

Test Plan:
- Reset then i_start; send 02 00 13 05 10 00 93 05 20 00 (valid every cycle) -> two write strobes: addr 0x0 data 0x00100513, then addr 0x4 data 0x00200593. o_done=1, o_coreSrst falls after the last write.
- Same frame with i_byteValid toggling every other cycle -> identical writes, with no byte lost or duplicated across WRITE cycles.
- Length 01 04 (1025 > MAX_WORDS) -> ERROR after LEN_HI, no writes, o_byteReady=0, o_coreSrst=1. A following i_start recovers.
- Length 00 00 -> no writes, DONE; o_coreSrst=0 the cycle after the second length byte.
- Drop i_arst_n after the 3rd byte of word 0 -> all outputs return to reset values asynchronously; a fresh frame then loads correctly.
- With INSTR_MEM_LOADER_CHECKSUM_EN: frame 01 00 13 05 10 00 + checksum 0x07 -> DONE. Checksum 0x08 -> ERROR, one write, o_coreSrst=1.

Source files
------------

// File: rtl/pa_riscv_pkg.sv
// Shared types and helpers for the instruction-memory loader.
package pa_riscv;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    WORD   = 3'd3,
    WRITE  = 3'd4,
    CHECK  = 3'd5,
    DONE   = 3'd6,
    ERROR  = 3'd7
  } loaderState_t;

  localparam int LOADER_LEN_BYTES = 2;

  function automatic logic byte_ready_in(input loaderState_t s);
    return s inside {LEN_LO, LEN_HI, WORD, CHECK};
  endfunction

  function automatic logic busy_in(input loaderState_t s);
    return s inside {LEN_LO, LEN_HI, WORD, WRITE, CHECK};
  endfunction

  function automatic logic [7:0] checksum_step(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Byte-lane assembler: collects four bytes little-endian into one 32-bit word.
// The completing byte is merged combinationally so the word is usable on that edge.
module loader_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [23:0] lane_r;
  logic [1:0]  byte_cnt_r;

  // Lower three lanes and the lane counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_r     <= 24'h00_0000;
      byte_cnt_r <= 2'd0;
    end else if (clear) begin
      lane_r     <= 24'h00_0000;
      byte_cnt_r <= 2'd0;
    end else if (byte_en) begin
      case (byte_cnt_r)
        2'd0:    lane_r[7:0]   <= byte_data;
        2'd1:    lane_r[15:8]  <= byte_data;
        2'd2:    lane_r[23:16] <= byte_data;
        default: lane_r        <= lane_r;
      endcase
      byte_cnt_r <= byte_cnt_r + 2'd1;
    end else begin
      lane_r     <= lane_r;
      byte_cnt_r <= byte_cnt_r;
    end
  end

  // Top lane comes straight from the incoming byte
  always_comb begin
    word          = {byte_data, lane_r};
    word_complete = byte_en && (byte_cnt_r == 2'd3);
  end

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory,
// holding the core in reset until done. Define INSTR_MEM_LOADER_CHECKSUM_EN for a trailing XOR byte.
module instr_mem_loader
  import pa_riscv::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          MAX_WORDS    = 1024
) (
  input  logic        i_clk,
  input  logic        i_arst_n,
  input  logic        i_start,
  input  logic        i_byteValid,
  input  logic [7:0]  i_byteData,
  output logic        o_byteReady,
  output logic        o_imemWriteEn,
  output logic [31:0] o_imemWriteAddress,
  output logic [31:0] o_imemWriteData,
  output logic        o_coreSrst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error
);

  localparam int               LEN_W   = 8 * LOADER_LEN_BYTES;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  localparam loaderState_t     END_STATE = CHECK;
`else
  localparam loaderState_t     END_STATE = DONE;
`endif

  loaderState_t     state_r;
  loaderState_t     state_s;
  logic [7:0]       len_lo_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] index_r;
  logic [LEN_W-1:0] len_full_s;
  logic             accept_s;
  logic             asm_clear_s;
  logic             asm_en_s;
  logic [31:0]      word_s;
  logic             word_complete_s;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  logic [7:0]       csum_r;
`endif

  // Handshake qualifiers
  always_comb begin
    accept_s   = i_byteValid && o_byteReady;
    asm_en_s   = accept_s && (state_r == WORD);
    len_full_s = {i_byteData, len_lo_r};
  end

  loader_word_assembler u_word_assembler (
    .clk           (i_clk),
    .rst_n         (i_arst_n),
    .clear         (asm_clear_s),
    .byte_en       (asm_en_s),
    .byte_data     (i_byteData),
    .word          (word_s),
    .word_complete (word_complete_s)
  );

  // Next-state decode
  always_comb begin
    state_s     = state_r;
    asm_clear_s = 1'b0;
    case (state_r)
      IDLE, DONE, ERROR: begin
        if (i_start) begin
          state_s     = LEN_LO;
          asm_clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      LEN_LO: begin
        if (accept_s) state_s = LEN_HI;
        else          state_s = LEN_LO;
      end
      LEN_HI: begin
        if (!accept_s)                             state_s = LEN_HI;
        else if (len_full_s == {LEN_W{1'b0}})      state_s = END_STATE;
        else if (len_full_s > MAX_LEN)             state_s = ERROR;
        else                                       state_s = WORD;
      end
      WORD: begin
        if (word_complete_s) state_s = WRITE;
        else                 state_s = WORD;
      end
      WRITE: begin
        if (index_r + LEN_W'(1) == len_r) state_s = END_STATE;
        else                              state_s = WORD;
      end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (!accept_s)                  state_s = CHECK;
        else if (i_byteData == csum_r)  state_s = DONE;
        else                            state_s = ERROR;
      end
`endif
      default: state_s = IDLE;
    endcase
  end

  // State register with outputs registered from the next state
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_r            <= IDLE;
      o_byteReady        <= 1'b0;
      o_imemWriteEn      <= 1'b0;
      o_imemWriteAddress <= 32'h0000_0000;
      o_imemWriteData    <= 32'h0000_0000;
      o_coreSrst         <= 1'b1;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_error            <= 1'b0;
    end else begin
      state_r       <= state_s;
      o_byteReady   <= byte_ready_in(state_s);
      o_busy        <= busy_in(state_s);
      o_coreSrst    <= (state_s != DONE);
      o_done        <= (state_s == DONE);
      o_error       <= (state_s == ERROR);
      o_imemWriteEn <= (state_s == WRITE);
      if (state_s == WRITE) begin
        o_imemWriteAddress <= BASE_ADDRESS + {{(30-LEN_W){1'b0}}, index_r, 2'b00};
        o_imemWriteData    <= word_s;
      end else begin
        o_imemWriteAddress <= o_imemWriteAddress;
        o_imemWriteData    <= o_imemWriteData;
      end
    end
  end

  // Frame length and word index
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      len_lo_r <= 8'h00;
      len_r    <= {LEN_W{1'b0}};
      index_r  <= {LEN_W{1'b0}};
    end else begin
      if (state_r == LEN_LO && accept_s) len_lo_r <= i_byteData;
      else                               len_lo_r <= len_lo_r;
      if (state_r == LEN_HI && accept_s) begin
        len_r   <= len_full_s;
        index_r <= {LEN_W{1'b0}};
      end else if (state_r == WRITE) begin
        len_r   <= len_r;
        index_r <= index_r + LEN_W'(1);
      end else begin
        len_r   <= len_r;
        index_r <= index_r;
      end
    end
  end

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  // Running XOR over length and word bytes
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      csum_r <= 8'h00;
    end else if (asm_clear_s) begin
      csum_r <= 8'h00;
    end else if (accept_s && (state_r inside {LEN_LO, LEN_HI, WORD})) begin
      csum_r <= checksum_step(csum_r, i_byteData);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a frame-level model.
module tb_instr_mem_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst_n, start, bvalid;
  logic [7:0]  bdata;
  logic        ready, we, core_srst, busy, done, err;
  logic [31:0] waddr, wdata;

  instr_mem_loader #(.BASE_ADDRESS(BASE), .MAX_WORDS(MAXW)) dut (
    .i_clk              (clk),
    .i_arst_n           (rst_n),
    .i_start            (start),
    .i_byteValid        (bvalid),
    .i_byteData         (bdata),
    .o_byteReady        (ready),
    .o_imemWriteEn      (we),
    .o_imemWriteAddress (waddr),
    .o_imemWriteData    (wdata),
    .o_coreSrst         (core_srst),
    .o_busy             (busy),
    .o_done             (done),
    .o_error            (err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  pay[$];
  logic [7:0]  frame[$];
  logic [31:0] got_addr[$], got_data[$];
  logic [31:0] exp_addr[$], exp_data[$];
  int          exp_len;
  bit          len_err, exp_err, exp_done;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
  bit          corrupt;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (we) begin
      got_addr.push_back(waddr);
      got_data.push_back(wdata);
    end
  end

  // Frame-level reference: parse the payload into expected writes and final status
  task automatic model_frame();
    logic [7:0] x;
    frame = pay;
    exp_addr.delete();
    exp_data.delete();
    exp_len = int'(pay[0]) + 256 * int'(pay[1]);
    len_err = (exp_len > MAXW);
    exp_err = len_err;
    if (!len_err) begin
      for (int i = 0; i < exp_len; i++) begin
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back({pay[2+4*i+3], pay[2+4*i+2], pay[2+4*i+1], pay[2+4*i]});
      end
    end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    if (!len_err) begin
      x = 8'h00;
      foreach (pay[i]) x = x ^ pay[i];
      frame.push_back(corrupt ? (x ^ 8'h0F) : x);
      exp_err = corrupt;
    end
`else
    x = 8'h00;
`endif
    exp_done = !exp_err;
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_ready"}, ready, 1'b0);
    check_eq({tag, "_we"}, we, 1'b0);
    check_eq({tag, "_waddr"}, waddr, 32'h0);
    check_eq({tag, "_wdata"}, wdata, 32'h0);
    check_eq({tag, "_core_srst"}, core_srst, 1'b1);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_error"}, err, 1'b0);
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    got_addr.delete();
    got_data.delete();
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy", busy, 1'b1);
    check_eq("start_core_srst", core_srst, 1'b1);
    check_eq("start_done_clr", done, 1'b0);
    check_eq("start_error_clr", err, 1'b0);
    check_eq("start_ready", ready, 1'b1);
  endtask

  // Cycle-exact checks one cycle after byte kk is accepted
  task automatic post_check(input int kk);
    int w;
    w = (kk - 2) / 4;
    if (!len_err && kk >= 2 && ((kk - 2) % 4) == 3 && w < exp_len) begin
      check_eq("we_latency", we, 1'b1);
      check_eq("write_addr", waddr, exp_addr[w]);
      check_eq("write_data", wdata, exp_data[w]);
      check_eq("ready_in_write", ready, 1'b0);
    end
    if (kk == 1 && len_err) begin
      check_eq("lenerr_error", err, 1'b1);
      check_eq("lenerr_ready", ready, 1'b0);
      check_eq("lenerr_core_srst", core_srst, 1'b1);
    end
`ifndef INSTR_MEM_LOADER_CHECKSUM_EN
    if (kk == 1 && exp_len == 0) begin
      check_eq("len0_done", done, 1'b1);
      check_eq("len0_core_srst", core_srst, 1'b0);
    end
`endif
  endtask

  task automatic send_frame(input int mode, input int limit);
    int   k = 0;
    int   pend = -1;
    int   cyc = 0;
    bit   alt = 1'b0;
    bit   v;
    logic rdy;
    while (cyc < 4000) begin
      @(negedge clk);
      if (pend >= 0) begin
        post_check(pend);
        pend = -1;
      end
      if (k >= limit) break;
      rdy = ready;
      case (mode)
        0:       v = 1'b1;
        1:       begin v = alt; alt = ~alt; end
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bvalid = v;
      bdata  = v ? frame[k] : 8'($urandom);
      start  = (mode == 2) && ($urandom_range(0, 15) == 0);
      @(posedge clk);
      cyc++;
      if (v && rdy) begin
        pend = k;
        k++;
      end
    end
    bvalid = 1'b0;
    start  = 1'b0;
    check_eq("bytes_accepted", 32'(k), 32'(limit));
  endtask

  task automatic finish_frame();
    int n;
    repeat (2) @(negedge clk);
    check_eq("final_done", done, exp_done);
    check_eq("final_error", err, exp_err);
    check_eq("final_core_srst", core_srst, !exp_done);
    check_eq("final_busy", busy, 1'b0);
    check_eq("final_ready", ready, 1'b0);
    check_eq("write_count", 32'(got_addr.size()), 32'(exp_addr.size()));
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq("seq_addr", got_addr[i], exp_addr[i]);
      check_eq("seq_data", got_data[i], exp_data[i]);
    end
    if (exp_addr.size() > 0) check_eq("addr_hold", waddr, exp_addr[exp_addr.size()-1]);
  endtask

  task automatic run_frame(input int mode);
    model_frame();
    do_start();
    send_frame(mode, frame.size());
    finish_frame();
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    bvalid = 1'b0;
    bdata  = 8'h00;
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    corrupt = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check_reset("por");
    rst_n = 1'b1;

    pay = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    run_frame(0);
    run_frame(1);

    pay = '{8'h01, 8'h04};
    run_frame(0);
    pay = '{8'h00, 8'h00};
    run_frame(0);

`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
    pay = '{8'h01, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00};
    run_frame(0);
    corrupt = 1'b1;
    run_frame(0);
    corrupt = 1'b0;
`endif

    // Async reset after the third byte of word 0, then a clean reload
    pay = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    model_frame();
    do_start();
    send_frame(0, 5);
    #2 rst_n = 1'b0;
    #1 check_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(0);

    for (int f = 0; f < 10; f++) begin
      int n;
      pay.delete();
      if ($urandom_range(0, 5) == 0) begin
        n = $urandom_range(MAXW + 1, 65535);
        pay.push_back(n[7:0]);
        pay.push_back(n[15:8]);
      end else begin
        n = $urandom_range(0, 6);
        pay.push_back(n[7:0]);
        pay.push_back(n[15:8]);
        for (int j = 0; j < 4 * n; j++) pay.push_back(8'($urandom));
      end
`ifdef INSTR_MEM_LOADER_CHECKSUM_EN
      corrupt = ($urandom_range(0, 3) == 0);
`endif
      run_frame($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
